// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM with mem_ready wait handshake.
// Define MC_IMMLOGIC_EN to implement the ORI/ANDI zero-extend path.
module mc_ctrl_fsm #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               iord,
   output logic               irwrite,
   output logic               memwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic               zeroext,
   output logic [1:0]         pcsrc,
   output logic [2:0]         aluop,
   output logic               pcen,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 0,
      DECODE  = 1,
      MEMADR  = 2,
      MEMRD   = 3,
      MEMWB   = 4,
      MEMWR   = 5,
      RTYPEEX = 6,
      ALUWB   = 7,
      BEQEX   = 8,
      ADDIEX  = 9,
      IMMWB   = 10,
      JEX     = 11,
      ORIEX   = 12,
      ANDIEX  = 13
   } state_t;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
`ifdef MC_IMMLOGIC_EN
   localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
`endif

   state_t state_q;
   state_t state_d;
   logic   irwrite_c;
   logic   memwrite_c;
   logic   regwrite_c;
   logic   pcen_c;
   logic   illegal_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

`ifdef MC_IMMLOGIC_EN
   // remembers that IMMWB was entered from ORIEX/ANDIEX
   logic imm_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) imm_q <= 1'b0;
      else        imm_q <= (state_q == ORIEX) ||
                           (state_q == ANDIEX);
   end
`endif

   always_comb begin
      state_d    = FETCH;
      iord       = 1'b0;
      irwrite_c  = 1'b0;
      memwrite_c = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_c = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      zeroext    = 1'b0;
      pcsrc      = 2'b00;
      aluop      = 3'b000;
      pcen_c     = 1'b0;
      illegal_c  = 1'b0;
      unique case (state_q)
         FETCH: begin
            alusrcb   = 2'b01;
            irwrite_c = mem_ready;
            pcen_c    = mem_ready;
            state_d   = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            unique case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
`ifdef MC_IMMLOGIC_EN
               OP_ORI:       state_d = ORIEX;
               OP_ANDI:      state_d = ANDIEX;
`endif
               default: begin
                  illegal_c = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            if (op == OP_LW)      state_d = MEMRD;
            else if (op == OP_SW) state_d = MEMWR;
            else                  state_d = FETCH;
         end
         MEMRD: begin
            iord    = 1'b1;
            state_d = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_c = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_c = 1'b1;
            state_d    = mem_ready ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 3'b010;
            state_d = ALUWB;
         end
         ALUWB: begin
            regdst     = 1'b1;
            regwrite_c = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 3'b001;
            pcsrc   = 2'b01;
            pcen_c  = zero;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = IMMWB;
         end
         IMMWB: begin
            regwrite_c = 1'b1;
`ifdef MC_IMMLOGIC_EN
            zeroext    = imm_q;
`endif
         end
         JEX: begin
            pcsrc  = 2'b10;
            pcen_c = 1'b1;
         end
`ifdef MC_IMMLOGIC_EN
         ORIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            zeroext = 1'b1;
            aluop   = 3'b011;
            state_d = IMMWB;
         end
         ANDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            zeroext = 1'b1;
            aluop   = 3'b100;
            state_d = IMMWB;
         end
`endif
         default: state_d = FETCH;
      endcase
   end

   // strobes are held off for the whole time reset is asserted
   assign irwrite  = irwrite_c  & reset;
   assign memwrite = memwrite_c & reset;
   assign regwrite = regwrite_c & reset;
   assign pcen     = pcen_c     & reset;
   assign illegal  = illegal_c  & reset;
   assign state_o  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm.
// Outputs are packed into one vector and compared per cycle.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       iord, irwrite, memwrite, regdst, memtoreg;
   logic       regwrite, alusrca, zeroext, pcen, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [3:0] state_o;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .iord      (iord),
      .irwrite   (irwrite),
      .memwrite  (memwrite),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .regwrite  (regwrite),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .zeroext   (zeroext),
      .pcsrc     (pcsrc),
      .aluop     (aluop),
      .pcen      (pcen),
      .illegal   (illegal),
      .state_o   (state_o)
   );

   // {iord,irw,mw,rd,m2r,rw,asa}_asb_zx_pcs_aop_{pcen,ill}
   logic [16:0] outs;
   assign outs = {iord, irwrite, memwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, zeroext, pcsrc,
                  aluop, pcen, illegal};

   localparam logic [16:0] F_RDY = 17'b0100000_01_0_00_000_10;
   localparam logic [16:0] F_WT  = 17'b0000000_01_0_00_000_00;
   localparam logic [16:0] F_RST = 17'b0000000_01_0_00_000_00;
   localparam logic [16:0] DEC   = 17'b0000000_11_0_00_000_00;
   localparam logic [16:0] DECI  = 17'b0000000_11_0_00_000_01;
   localparam logic [16:0] ADR   = 17'b0000001_10_0_00_000_00;
   localparam logic [16:0] MRD   = 17'b1000000_00_0_00_000_00;
   localparam logic [16:0] MWB   = 17'b0000110_00_0_00_000_00;
   localparam logic [16:0] MWR   = 17'b1010000_00_0_00_000_00;
   localparam logic [16:0] REX   = 17'b0000001_00_0_00_010_00;
   localparam logic [16:0] AWB   = 17'b0001010_00_0_00_000_00;
   localparam logic [16:0] BEQ1  = 17'b0000001_00_0_01_001_10;
   localparam logic [16:0] BEQ0  = 17'b0000001_00_0_01_001_00;
   localparam logic [16:0] IWB0  = 17'b0000010_00_0_00_000_00;
   localparam logic [16:0] JMP   = 17'b0000000_00_0_10_000_10;
`ifdef MC_IMMLOGIC_EN
   localparam logic [16:0] ORX   = 17'b0000001_10_1_00_011_00;
   localparam logic [16:0] ANX   = 17'b0000001_10_1_00_100_00;
   localparam logic [16:0] IWB1  = 17'b0000010_00_1_00_000_00;
`endif

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // check one cycle at negedge+1, then advance to the next negedge
   task automatic cyc(input string tag,
                      input logic [3:0] s,
                      input logic [16:0] o);
      #1;
      chk({tag, ".st"}, {28'd0, state_o}, {28'd0, s});
      chk({tag, ".out"}, {15'd0, outs}, {15'd0, o});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b0;
      op        = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #3;
      chk("rst.st", {28'd0, state_o}, 32'd0);
      chk("rst.out", {15'd0, outs}, {15'd0, F_RST});
      @(negedge clk);
      reset = 1'b1;
      op    = 6'b100011;
      cyc("rel.f", 4'd0, F_RDY);
      cyc("lw.dec", 4'd1, DEC);
      cyc("lw.adr", 4'd2, ADR);
      cyc("lw.rd", 4'd3, MRD);
      cyc("lw.wb", 4'd4, MWB);

      cyc("lws.f", 4'd0, F_RDY);
      cyc("lws.dec", 4'd1, DEC);
      cyc("lws.adr", 4'd2, ADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lws.rdw", 4'd3, MRD);
      mem_ready = 1'b1;
      cyc("lws.rd", 4'd3, MRD);
      cyc("lws.wb", 4'd4, MWB);

      mem_ready = 1'b0;
      op = 6'b101011;
      cyc("f.stall", 4'd0, F_WT);
      mem_ready = 1'b1;
      cyc("sw.f", 4'd0, F_RDY);
      cyc("sw.dec", 4'd1, DEC);
      cyc("sw.adr", 4'd2, ADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) cyc("sw.wrw", 4'd5, MWR);
      mem_ready = 1'b1;
      cyc("sw.wr", 4'd5, MWR);

      op = 6'b000000;
      cyc("r.f", 4'd0, F_RDY);
      cyc("r.dec", 4'd1, DEC);
      cyc("r.ex", 4'd6, REX);
      cyc("r.wb", 4'd7, AWB);

      op = 6'b000100;
      cyc("beq1.f", 4'd0, F_RDY);
      cyc("beq1.dec", 4'd1, DEC);
      zero = 1'b1;
      cyc("beq1.ex", 4'd8, BEQ1);
      zero = 1'b0;
      cyc("beq0.f", 4'd0, F_RDY);
      cyc("beq0.dec", 4'd1, DEC);
      cyc("beq0.ex", 4'd8, BEQ0);

      op = 6'b001000;
      cyc("addi.f", 4'd0, F_RDY);
      cyc("addi.dec", 4'd1, DEC);
      cyc("addi.ex", 4'd9, ADR);
      cyc("addi.wb", 4'd10, IWB0);

      op = 6'b000010;
      cyc("j.f", 4'd0, F_RDY);
      cyc("j.dec", 4'd1, DEC);
      cyc("j.ex", 4'd11, JMP);

      op = 6'b111111;
      cyc("ill.f", 4'd0, F_RDY);
      cyc("ill.dec", 4'd1, DECI);
      mem_ready = 1'b0;
      cyc("ill.f2", 4'd0, F_WT);
      mem_ready = 1'b1;

      op = 6'b001101;
      cyc("ori.f", 4'd0, F_RDY);
`ifdef MC_IMMLOGIC_EN
      cyc("ori.dec", 4'd1, DEC);
      cyc("ori.ex", 4'd12, ORX);
      cyc("ori.wb", 4'd10, IWB1);
      op = 6'b001100;
      cyc("andi.f", 4'd0, F_RDY);
      cyc("andi.dec", 4'd1, DEC);
      cyc("andi.ex", 4'd13, ANX);
      cyc("andi.wb", 4'd10, IWB1);
`else
      cyc("ori.dec", 4'd1, DECI);
      op = 6'b001100;
      cyc("andi.f", 4'd0, F_RDY);
      cyc("andi.dec", 4'd1, DECI);
`endif

      op = 6'b000000;
      cyc("mid.f", 4'd0, F_RDY);
      cyc("mid.dec", 4'd1, DEC);
      cyc("mid.ex", 4'd6, REX);
      reset = 1'b0;
      #1;
      chk("mid.rst.st", {28'd0, state_o}, 32'd0);
      chk("mid.rst.out", {15'd0, outs}, {15'd0, F_RST});
      @(negedge clk);
      reset = 1'b1;
      cyc("mid.f2", 4'd0, F_RDY);
      cyc("mid.dec2", 4'd1, DEC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
